// File: rtl/imem_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for the program loader.
//   rx_valid, rx_byte    : received byte strobe and data (source -> loader)
//   mem_we, mem_addr,
//   mem_wdata            : instruction-memory word write port (loader -> memory)
//   cpu_hold, busy, done,
//   error, words_loaded  : load status (loader -> system)
// modport master: byte source / observer side; modport slave: the loader itself.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [15:0]           words_loaded;

  modport master (
    output rx_valid, rx_byte,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, words_loaded
  );

  modport slave (
    input  rx_valid, rx_byte,
    output mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: frames a byte stream (SYNC, LEN_LO, LEN_HI, 4*N data
// bytes little-endian per word, XOR checksum), writes 32-bit words into the
// instruction memory and stalls the CPU while a load is running.
//   clk        : system clock, rising edge
//   btn_reset  : asynchronous, active-high reset
//   bus        : imem_loader_if.slave (byte input, memory write port, status)
module imem_loader #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input logic          clk,
  input logic          btn_reset,
  imem_loader_if.slave bus
);
  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR
  } state_t;

  state_t          state, state_d;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [15:0]     n_in;
  logic [7:0]      chk;
  logic [1:0]      lane;
  logic [23:0]     word_buf;
  logic [TO_W-1:0] to_cnt;
  logic            active;
  logic            last_word;
  logic            busy_d, hold_d, done_d, error_d;

  assign n_in      = {bus.rx_byte, len_lo};
  assign active    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHK);
  assign last_word = (lane == 2'd3) && ((bus.words_loaded + 16'd1) == len);

  // State register
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) state <= IDLE;
    else           state <= state_d;
  end

  // Next-state and next-output decode
  always_comb begin
    state_d = state;
    busy_d  = 1'b0;
    hold_d  = 1'b0;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state)
      IDLE, DONE, ERROR:
        if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) state_d = LEN_LO;
      LEN_LO:
        if (bus.rx_valid) state_d = LEN_HI;
      LEN_HI:
        if (bus.rx_valid) begin
          if (n_in == 16'd0)            state_d = CHK;
          else if (32'(n_in) > DEPTH)   state_d = ERROR;
          else                          state_d = DATA;
        end
      DATA:
        if (bus.rx_valid && last_word) state_d = CHK;
      CHK:
        if (bus.rx_valid) state_d = (bus.rx_byte == chk) ? DONE : ERROR;
      default:
        state_d = IDLE;
    endcase
    // Inter-byte timeout: to_cnt holds the idle cycles since the last byte
    if (active && !bus.rx_valid && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) state_d = ERROR;

    busy_d  = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA) || (state_d == CHK);
    hold_d  = busy_d || (state_d == ERROR);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  // Datapath, memory write port and registered status outputs
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      len_lo           <= 8'd0;
      len              <= 16'd0;
      chk              <= 8'd0;
      lane             <= 2'd0;
      word_buf         <= 24'd0;
      to_cnt           <= '0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= 32'd0;
      bus.words_loaded <= 16'd0;
      bus.busy         <= 1'b0;
      bus.cpu_hold     <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
    end else begin
      bus.mem_we   <= 1'b0;
      bus.busy     <= busy_d;
      bus.cpu_hold <= hold_d;
      bus.done     <= done_d;
      bus.error    <= error_d;

      if (bus.rx_valid || !active) to_cnt <= '0;
      else                         to_cnt <= to_cnt + TO_W'(1);

      case (state)
        IDLE, DONE, ERROR:
          if (state_d == LEN_LO) begin
            bus.words_loaded <= 16'd0;
            chk              <= 8'd0;
            lane             <= 2'd0;
          end
        LEN_LO:
          if (bus.rx_valid) len_lo <= bus.rx_byte;
        LEN_HI:
          if (bus.rx_valid) len <= n_in;
        DATA:
          if (bus.rx_valid) begin
            chk  <= chk ^ bus.rx_byte;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              // Word complete: write it one cycle after its last byte
              bus.mem_we       <= 1'b1;
              bus.mem_addr     <= ADDR_WIDTH'(bus.words_loaded);
              bus.mem_wdata    <= {bus.rx_byte, word_buf};
              bus.words_loaded <= bus.words_loaded + 16'd1;
            end else begin
              word_buf[{lane, 3'b000} +: 8] <= bus.rx_byte;
            end
          end
        default: ;
      endcase
    end
  end
endmodule
